// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shifter for the tiny MIPS datapath.
// SLL / SRL / SRA / ROTR by a variable amount, one bit position per clock.
// The FSM state is visible on dbg_state_o so checkers can follow the sequencing.
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// busy then stays high until the edge that raises done. done is a one-cycle
// pulse, and y is valid while done=1. y then holds until the next accepted
// start. A start that arrives while busy=1 is dropped and is not queued.
// busy is low during the FINISH cycle, so a new request can follow directly.

module shift_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5   // must equal $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       dbg_state_o
);

    // Operation encoding
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SHIFT  = 2'b01,
        S_FINISH = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q,    op_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0] y_q,     y_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] step_y;

    // One single-bit step of the latched operation applied to the current y
    always_comb begin
        step_y = y_q;
        unique case (op_q)
            OP_SLL:  step_y = {y_q[WIDTH-2:0], 1'b0};
            OP_SRL:  step_y = {1'b0, y_q[WIDTH-1:1]};
            OP_SRA:  step_y = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
            OP_ROTR: step_y = {y_q[0], y_q[WIDTH-1:1]};
            default: step_y = y_q;
        endcase
    end

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            // IDLE and FINISH both accept. FINISH always returns to IDLE
            // when no new request is taken.
            S_IDLE, S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    op_d    = op;
                    y_d     = a;
                    cnt_d   = shamt;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    y_d   = step_y;
                    cnt_d = cnt_q - SHW'(1);
                end else begin
                    // Count is exhausted, so y already holds the result.
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers. A synchronous reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_SLL;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign y           = y_q;
    assign dbg_state_o = state_q;

endmodule
